// File: rtl/axi_msg_fifo.sv
// Bidirectional message buffer: two circular FIFOs with rdy/ack handshakes.
// Define AXI_MSG_FIFO_STATS_EN to build the saturating producer-stall counters.
module axi_msg_fifo_ring #(
  parameter int W         = 64,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int W_CNT     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_rdy,
  input  logic [W-1:0]     p_data,
  output logic             p_ack,
  output logic             c_rdy,
  output logic [W-1:0]     c_data,
  input  logic             c_ack,
  output logic [W_CNT-1:0] count,
  output logic             afull,
  output logic [15:0]      stall_cnt
);
  localparam int W_PTR = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [W_PTR-1:0] head;
  logic [W_PTR-1:0] tail;
  logic [W_CNT-1:0] cnt;
  logic             ack_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (cnt == W_CNT'(DEPTH));
  assign empty = (cnt == '0);
  // ack_q blocks a second capture of the same offer
  assign push  = p_rdy & ~ack_q & ~full;
  assign pop   = c_ack & ~empty;

  assign p_ack  = ack_q;
  assign c_rdy  = ~empty;
  assign c_data = mem[head];
  assign count  = cnt;
  assign afull  = (cnt >= W_CNT'(AF_THRESH));

  // pointer, occupancy and ack state
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= push;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // storage write, contents survive reset
  always_ff @(posedge clk) begin
    if (push && !rst) mem[tail] <= p_data;
  end

`ifdef AXI_MSG_FIFO_STATS_EN
  logic [15:0] stall_q;

  // count refused offers, saturating
  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (p_rdy && full && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

module axi_msg_fifo #(
  parameter int W_MSG     = 64,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int W_CNT    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             o_in_msg_rdy,
  input  logic [W_MSG-1:0] o_in_msg,
  output logic             o_in_msg_ack,
  output logic             i_in_msg_rdy,
  output logic [W_MSG-1:0] i_in_msg,
  input  logic             i_in_msg_ack,
  input  logic             i_out_msg_rdy,
  input  logic [W_MSG-1:0] i_out_msg,
  output logic             i_out_msg_ack,
  output logic             o_out_msg_rdy,
  output logic [W_MSG-1:0] o_out_msg,
  input  logic             o_out_msg_ack,
  output logic [W_CNT-1:0] in_count,
  output logic [W_CNT-1:0] out_count,
  output logic             in_afull,
  output logic             out_afull,
  output logic [15:0]      in_stall_cnt,
  output logic [15:0]      out_stall_cnt
);

  axi_msg_fifo_ring #(
    .W(W_MSG), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .W_CNT(W_CNT)
  ) u_in (
    .clk(clk), .rst(rst),
    .p_rdy(o_in_msg_rdy), .p_data(o_in_msg), .p_ack(o_in_msg_ack),
    .c_rdy(i_in_msg_rdy), .c_data(i_in_msg), .c_ack(i_in_msg_ack),
    .count(in_count), .afull(in_afull), .stall_cnt(in_stall_cnt)
  );

  axi_msg_fifo_ring #(
    .W(W_MSG), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .W_CNT(W_CNT)
  ) u_out (
    .clk(clk), .rst(rst),
    .p_rdy(i_out_msg_rdy), .p_data(i_out_msg), .p_ack(i_out_msg_ack),
    .c_rdy(o_out_msg_rdy), .c_data(o_out_msg), .c_ack(o_out_msg_ack),
    .count(out_count), .afull(out_afull), .stall_cnt(out_stall_cnt)
  );

endmodule

// File: tb/tb_axi_msg_fifo.sv
// Directed bench for axi_msg_fifo, DEPTH=8, AF_THRESH=6.
// Inputs change 1ns after posedge; outputs sampled at the same point.
module tb_axi_msg_fifo;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         o_in_msg_rdy;
  logic [W-1:0] o_in_msg;
  logic         o_in_msg_ack;
  logic         i_in_msg_rdy;
  logic [W-1:0] i_in_msg;
  logic         i_in_msg_ack;
  logic         i_out_msg_rdy;
  logic [W-1:0] i_out_msg;
  logic         i_out_msg_ack;
  logic         o_out_msg_rdy;
  logic [W-1:0] o_out_msg;
  logic         o_out_msg_ack;
  logic [3:0]   in_count;
  logic [3:0]   out_count;
  logic         in_afull;
  logic         out_afull;
  logic [15:0]  in_stall_cnt;
  logic [15:0]  out_stall_cnt;

  int vec = 0;
  int err = 0;

`ifdef AXI_MSG_FIFO_STATS_EN
  localparam logic [15:0] EXP_STALL = 16'd5;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  axi_msg_fifo #(.W_MSG(W), .DEPTH(8), .AF_THRESH(6)) dut (
    .clk(clk), .rst(rst),
    .o_in_msg_rdy(o_in_msg_rdy), .o_in_msg(o_in_msg),
    .o_in_msg_ack(o_in_msg_ack),
    .i_in_msg_rdy(i_in_msg_rdy), .i_in_msg(i_in_msg),
    .i_in_msg_ack(i_in_msg_ack),
    .i_out_msg_rdy(i_out_msg_rdy), .i_out_msg(i_out_msg),
    .i_out_msg_ack(i_out_msg_ack),
    .o_out_msg_rdy(o_out_msg_rdy), .o_out_msg(o_out_msg),
    .o_out_msg_ack(o_out_msg_ack),
    .in_count(in_count), .out_count(out_count),
    .in_afull(in_afull), .out_afull(out_afull),
    .in_stall_cnt(in_stall_cnt), .out_stall_cnt(out_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    o_in_msg_rdy = 0; o_in_msg = '0; i_in_msg_ack = 0;
    i_out_msg_rdy = 0; i_out_msg = '0; o_out_msg_ack = 0;
    step(); step();
    rst = 1'b0;
    step();
    vec++;
    if ({i_in_msg_rdy, o_out_msg_rdy, o_in_msg_ack, i_out_msg_ack} !== 4'b0) begin
      err++;
      $display("FAIL reset_rdy_ack got=%b want=0000",
        {i_in_msg_rdy, o_out_msg_rdy, o_in_msg_ack, i_out_msg_ack});
    end
    vec++;
    if ({in_count, out_count, in_afull, out_afull} !== 10'b0) begin
      err++;
      $display("FAIL reset_cnt got in=%0d out=%0d af=%b%b want 0",
        in_count, out_count, in_afull, out_afull);
    end
    vec++;
    if (in_stall_cnt !== 16'd0 || out_stall_cnt !== 16'd0) begin
      err++;
      $display("FAIL reset_stall got=%0d/%0d want=0", in_stall_cnt, out_stall_cnt);
    end
    i_in_msg_ack = 1; o_out_msg_ack = 1;
    step();
    i_in_msg_ack = 0; o_out_msg_ack = 0;
    vec++;
    if (in_count !== 4'd0 || out_count !== 4'd0 || i_in_msg_rdy !== 1'b0) begin
      err++;
      $display("FAIL empty_pop got in=%0d out=%0d rdy=%b want 0/0/0",
        in_count, out_count, i_in_msg_rdy);
    end
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < 8; i++) begin
      o_in_msg_rdy = 1;
      o_in_msg = 64'h11 * (i + 1);
      step();
      vec++;
      if (o_in_msg_ack !== 1'b1 || in_count !== 4'(i + 1)) begin
        err++;
        $display("FAIL fill_ack[%0d] got ack=%b cnt=%0d want 1/%0d",
          i, o_in_msg_ack, in_count, i + 1);
      end
      vec++;
      if (in_afull !== (i + 1 >= 6)) begin
        err++;
        $display("FAIL fill_afull[%0d] got=%b want=%b", i, in_afull, (i + 1 >= 6));
      end
      o_in_msg_rdy = 0;
      step();
      vec++;
      if (o_in_msg_ack !== 1'b0) begin
        err++;
        $display("FAIL fill_pulse[%0d] got=%b want=0", i, o_in_msg_ack);
      end
    end
    o_in_msg_rdy = 1;
    o_in_msg = 64'h99;
    for (int c = 0; c < 5; c++) begin
      step();
      vec++;
      if (o_in_msg_ack !== 1'b0 || in_count !== 4'd8) begin
        err++;
        $display("FAIL full_refuse[%0d] got ack=%b cnt=%0d want 0/8",
          c, o_in_msg_ack, in_count);
      end
    end
    o_in_msg_rdy = 0;
    vec++;
    if (in_stall_cnt !== EXP_STALL || out_stall_cnt !== 16'd0) begin
      err++;
      $display("FAIL stall_cnt got=%0d/%0d want=%0d/0",
        in_stall_cnt, out_stall_cnt, EXP_STALL);
    end
  endtask

  task automatic test_drain_wrap();
    i_in_msg_ack = 1;
    for (int i = 0; i < 8; i++) begin
      vec++;
      if (i_in_msg_rdy !== 1'b1 || i_in_msg !== 64'h11 * (i + 1)) begin
        err++;
        $display("FAIL drain[%0d] got rdy=%b data=%h want 1/%h",
          i, i_in_msg_rdy, i_in_msg, 64'h11 * (i + 1));
      end
      step();
    end
    i_in_msg_ack = 0;
    vec++;
    if (i_in_msg_rdy !== 1'b0 || in_count !== 4'd0) begin
      err++;
      $display("FAIL drain_empty got rdy=%b cnt=%0d want 0/0", i_in_msg_rdy, in_count);
    end
    for (int i = 0; i < 20; i++) begin
      o_in_msg_rdy = 1;
      o_in_msg = 64'h100 + i;
      step();
      o_in_msg_rdy = 0;
      vec++;
      if (o_in_msg_ack !== 1'b1 || i_in_msg !== 64'h100 + i) begin
        err++;
        $display("FAIL wrap[%0d] got ack=%b data=%h want 1/%h",
          i, o_in_msg_ack, i_in_msg, 64'h100 + i);
      end
      i_in_msg_ack = 1;
      step();
      i_in_msg_ack = 0;
    end
    vec++;
    if (in_count !== 4'd0 || i_in_msg_rdy !== 1'b0) begin
      err++;
      $display("FAIL wrap_end got cnt=%0d rdy=%b want 0/0", in_count, i_in_msg_rdy);
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 4; i++) begin
      o_in_msg_rdy = 1; o_in_msg = 64'hC1 + i;
      step();
      o_in_msg_rdy = 0;
      step();
    end
    o_in_msg_rdy = 1; o_in_msg = 64'hC5; i_in_msg_ack = 1;
    step();
    o_in_msg_rdy = 0; i_in_msg_ack = 0;
    vec++;
    if (in_count !== 4'd4 || o_in_msg_ack !== 1'b1 || i_in_msg !== 64'hC2) begin
      err++;
      $display("FAIL simul4 got cnt=%0d ack=%b head=%h want 4/1/c2",
        in_count, o_in_msg_ack, i_in_msg);
    end
    step();
    i_in_msg_ack = 1;
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (i_in_msg !== 64'hC2 + i) begin
        err++;
        $display("FAIL simul4_drain[%0d] got=%h want=%h", i, i_in_msg, 64'hC2 + i);
      end
      step();
    end
    i_in_msg_ack = 0;
    for (int i = 0; i < 8; i++) begin
      o_in_msg_rdy = 1; o_in_msg = 64'hD0 + i;
      step();
      o_in_msg_rdy = 0;
      step();
    end
    o_in_msg_rdy = 1; o_in_msg = 64'hEE; i_in_msg_ack = 1;
    step();
    i_in_msg_ack = 0;
    vec++;
    if (in_count !== 4'd7 || o_in_msg_ack !== 1'b0 || i_in_msg !== 64'hD1) begin
      err++;
      $display("FAIL simul_full got cnt=%0d ack=%b head=%h want 7/0/d1",
        in_count, o_in_msg_ack, i_in_msg);
    end
    step();
    o_in_msg_rdy = 0;
    vec++;
    if (in_count !== 4'd8 || o_in_msg_ack !== 1'b1) begin
      err++;
      $display("FAIL simul_retry got cnt=%0d ack=%b want 8/1", in_count, o_in_msg_ack);
    end
    i_in_msg_ack = 1;
    for (int i = 0; i < 8; i++) begin
      vec++;
      if (i_in_msg !== ((i == 7) ? 64'hEE : 64'hD1 + i)) begin
        err++;
        $display("FAIL simul_drain[%0d] got=%h want=%h",
          i, i_in_msg, ((i == 7) ? 64'hEE : 64'hD1 + i));
      end
      step();
    end
    i_in_msg_ack = 0;
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 3; i++) begin
      o_in_msg_rdy = 1; o_in_msg = 64'h5A + i;
      i_out_msg_rdy = 1; i_out_msg = 64'hA5 + i;
      step();
      vec++;
      if (o_in_msg_ack !== 1'b1 || i_out_msg_ack !== 1'b1) begin
        err++;
        $display("FAIL conc_ack[%0d] got=%b%b want=11", i, o_in_msg_ack, i_out_msg_ack);
      end
      o_in_msg_rdy = 0; i_out_msg_rdy = 0;
      step();
    end
    o_out_msg_ack = 1;
    step();
    o_out_msg_ack = 0;
    vec++;
    if (in_count !== 4'd3 || out_count !== 4'd2) begin
      err++;
      $display("FAIL conc_cnt got in=%0d out=%0d want 3/2", in_count, out_count);
    end
    vec++;
    if (i_in_msg !== 64'h5A || o_out_msg !== 64'hA6) begin
      err++;
      $display("FAIL conc_head got in=%h out=%h want 5a/a6", i_in_msg, o_out_msg);
    end
    i_in_msg_ack = 1; o_out_msg_ack = 1;
    step();
    vec++;
    if (i_in_msg !== 64'h5B || o_out_msg !== 64'hA7) begin
      err++;
      $display("FAIL conc_head2 got in=%h out=%h want 5b/a7", i_in_msg, o_out_msg);
    end
    step();
    o_out_msg_ack = 0;
    vec++;
    if (i_in_msg !== 64'h5C || o_out_msg_rdy !== 1'b0 || out_count !== 4'd0) begin
      err++;
      $display("FAIL conc_end got in=%h ordy=%b ocnt=%0d want 5c/0/0",
        i_in_msg, o_out_msg_rdy, out_count);
    end
    step();
    i_in_msg_ack = 0;
    vec++;
    if (in_count !== 4'd0) begin
      err++;
      $display("FAIL conc_in_empty got=%0d want=0", in_count);
    end
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 5; i++) begin
      o_in_msg_rdy = 1; o_in_msg = 64'hF0 + i;
      step();
      o_in_msg_rdy = 0;
      step();
    end
    vec++;
    if (in_count !== 4'd5) begin
      err++;
      $display("FAIL rst_pre got=%0d want=5", in_count);
    end
    o_in_msg_rdy = 1; o_in_msg = 64'h77; rst = 1;
    step();
    rst = 0;
    vec++;
    if (in_count !== 4'd0 || o_in_msg_ack !== 1'b0 || i_in_msg_rdy !== 1'b0
        || o_out_msg_rdy !== 1'b0 || in_stall_cnt !== 16'd0) begin
      err++;
      $display("FAIL rst_flight got cnt=%0d ack=%b rdy=%b%b stall=%0d want 0/0/00/0",
        in_count, o_in_msg_ack, i_in_msg_rdy, o_out_msg_rdy, in_stall_cnt);
    end
    step();
    o_in_msg_rdy = 0;
    vec++;
    if (o_in_msg_ack !== 1'b1 || in_count !== 4'd1 || i_in_msg !== 64'h77) begin
      err++;
      $display("FAIL rst_repush got ack=%b cnt=%0d data=%h want 1/1/77",
        o_in_msg_ack, in_count, i_in_msg);
    end
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_drain_wrap();
    test_simul();
    test_concurrent();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
